// File: rtl/i2c_edge_detect.sv
// Multi-channel input synchroniser with glitch filter and edge pulses.
// Each channel runs its own sync chain, stability counter and pulse logic.

module i2c_edge_lane #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 3,
  parameter logic INIT_LEVEL  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic level,
  output logic lh,
  output logic hl,
  output logic lh_nx,
  output logic hl_nx
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CMAX = CW'(FILTER_LEN - 1);

  typedef enum logic {IDLE, PENDING} st_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  st_t                    st, st_nx;
  logic [CW-1:0]          cnt, cnt_nx;
  logic                   diff, accept, level_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {SYNC_STAGES{INIT_LEVEL}};
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], in};
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign diff   = (s != level);
  assign accept = diff && (cnt == CMAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= IDLE;
      cnt   <= '0;
      level <= INIT_LEVEL;
      lh    <= 1'b0;
      hl    <= 1'b0;
    end else begin
      st    <= st_nx;
      cnt   <= cnt_nx;
      level <= level_nx;
      lh    <= lh_nx;
      hl    <= hl_nx;
    end
  end

  // Any reversion or acceptance drops back to IDLE with the counter cleared.
  always_comb begin
    st_nx  = IDLE;
    cnt_nx = '0;
    if (diff && !accept) begin
      st_nx  = PENDING;
      cnt_nx = (st == PENDING) ? cnt + 1'b1 : CW'(1);
    end
  end

  always_comb begin
    level_nx = accept ? s : level;
    lh_nx    = accept &  s;
    hl_nx    = accept & ~s;
  end
endmodule

module i2c_edge_detect #(
  parameter int   WIDTH       = 2,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 3,
  parameter logic INIT_LEVEL  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] low_high_trans,
  output logic [WIDTH-1:0] high_low_trans,
  output logic             any_trans
);
  logic [WIDTH-1:0] lh_nx, hl_nx;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    i2c_edge_lane #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN),
      .INIT_LEVEL (INIT_LEVEL)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .in    (in[i]),
      .level (level[i]),
      .lh    (low_high_trans[i]),
      .hl    (high_low_trans[i]),
      .lh_nx (lh_nx[i]),
      .hl_nx (hl_nx[i])
    );
  end

  // Built from the same next-state terms so it lands in the pulse cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) any_trans <= 1'b0;
    else     any_trans <= |(lh_nx | hl_nx);
  end
endmodule

// File: tb/tb_i2c_edge_detect.sv
// Scoreboard bench: expected pulses are queued at drive time with their due edge.
module tb_i2c_edge_detect;
  typedef struct {int at; logic [1:0] lh; logic [1:0] hl;} ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] in0 = 2'b11;
  logic [0:0] in1 = 1'b1;
  logic [1:0] level0, lh0, hl0;
  logic [0:0] level1, lh1, hl1;
  logic       any0, any1;

  int   edges = 0;
  int   passed = 0, total = 0;
  ev_t  q0[$], q1[$];
  logic [1:0] e_lh, e_hl, e_lvl0;
  logic [0:0] e_lvl1;

  i2c_edge_detect dut0 (
    .clk(clk), .rst(rst), .in(in0), .level(level0),
    .low_high_trans(lh0), .high_low_trans(hl0), .any_trans(any0)
  );

  i2c_edge_detect #(.WIDTH(1), .FILTER_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .in(in1), .level(level1),
    .low_high_trans(lh1), .high_low_trans(hl1), .any_trans(any1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  task automatic test_reset();
    rst = 1'b1; in0 = 2'b11; in1 = 1'b1;
    e_lvl0 = 2'b11; e_lvl1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({level0, lh0, hl0, any0} !== {2'b11, 2'b00, 2'b00, 1'b0}) begin
      $display("FAIL reset_dut0 got lvl=%b lh=%b hl=%b any=%b want lvl=11 lh=00 hl=00 any=0",
               level0, lh0, hl0, any0);
    end else passed++;
    total++;
    if ({level1, lh1, hl1, any1} !== {1'b1, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL reset_dut1 got lvl=%b lh=%b hl=%b any=%b want 1 0 0 0", level1, lh1, hl1, any1);
    end else passed++;
    rst = 1'b0;
  endtask

  task automatic run0(input string name, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      e_lh = 2'b00; e_hl = 2'b00;
      if (q0.size() > 0 && q0[0].at == edges) begin
        e_lh = q0[0].lh; e_hl = q0[0].hl;
        e_lvl0 = (e_lvl0 | e_lh) & ~e_hl;
        void'(q0.pop_front());
      end
      total++;
      if ({level0, lh0, hl0, any0} !== {e_lvl0, e_lh, e_hl, |{e_lh, e_hl}}) begin
        $display("FAIL %s edge %0d got lvl=%b lh=%b hl=%b any=%b want lvl=%b lh=%b hl=%b any=%b",
                 name, edges, level0, lh0, hl0, any0, e_lvl0, e_lh, e_hl, |{e_lh, e_hl});
      end else passed++;
    end
  endtask

  task automatic test_idle();
    run0("idle", 20);
  endtask

  task automatic test_fall_rise();
    in0[0] = 1'b0; q0.push_back('{edges + 5, 2'b00, 2'b01});
    run0("fall0", 8);
    in0[0] = 1'b1; q0.push_back('{edges + 5, 2'b01, 2'b00});
    run0("rise0", 8);
  endtask

  task automatic test_glitch();
    in0[1] = 1'b0;
    run0("glitch_lo", 2);
    in0[1] = 1'b1;
    run0("glitch_hi", 6);
    total++;
    if (dut0.g_lane[1].u_lane.cnt !== 2'd0) begin
      $display("FAIL glitch_cnt got %0d want 0", dut0.g_lane[1].u_lane.cnt);
    end else passed++;
  endtask

  task automatic test_back_to_back();
    in0 = 2'b00; q0.push_back('{edges + 5, 2'b00, 2'b11});
    run0("both_fall", 10);
    in0 = 2'b11; q0.push_back('{edges + 5, 2'b11, 2'b00});
    run0("both_rise", 8);
  endtask

  task automatic test_reset_pending();
    in0[0] = 1'b0;
    run0("pend", 2);
    rst = 1'b1;
    #1;
    total++;
    if ({level0, lh0, hl0, any0} !== {2'b11, 2'b00, 2'b00, 1'b0}) begin
      $display("FAIL rst_pending got lvl=%b lh=%b hl=%b any=%b want lvl=11 lh=00 hl=00 any=0",
               level0, lh0, hl0, any0);
    end else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    e_lvl0 = 2'b11;
    q0.push_back('{edges + 5, 2'b00, 2'b01});
    run0("post_rst", 8);
    in0[0] = 1'b1; q0.push_back('{edges + 5, 2'b01, 2'b00});
    run0("post_rst_rise", 8);
  endtask

  task automatic test_toggle();
    logic v;
    v = 1'b1;
    for (int k = 0; k < 56; k++) begin
      if (k < 50) begin
        v = ~v;
        in0[0] = v; in1 = v;
        q1.push_back('{edges + 3, {1'b0, v}, {1'b0, ~v}});
      end
      @(posedge clk); #1;
      total++;
      if ({lh0, hl0, any0, level0} !== {2'b00, 2'b00, 1'b0, 2'b11}) begin
        $display("FAIL toggle_f3 edge %0d got lh=%b hl=%b any=%b lvl=%b want 00 00 0 11",
                 edges, lh0, hl0, any0, level0);
      end else passed++;
      e_lh = 2'b00; e_hl = 2'b00;
      if (q1.size() > 0 && q1[0].at == edges) begin
        e_lh = q1[0].lh; e_hl = q1[0].hl;
        e_lvl1 = (e_lvl1 | e_lh[0]) & ~e_hl[0];
        void'(q1.pop_front());
      end
      total++;
      if ({lh1, hl1, any1, level1} !== {e_lh[0], e_hl[0], e_lh[0] | e_hl[0], e_lvl1}) begin
        $display("FAIL toggle_f1 edge %0d got lh=%b hl=%b any=%b lvl=%b want lh=%b hl=%b any=%b lvl=%b",
                 edges, lh1, hl1, any1, level1, e_lh[0], e_hl[0], e_lh[0] | e_hl[0], e_lvl1);
      end else passed++;
    end
    total++;
    if (q1.size() != 0) begin
      $display("FAIL toggle_f1_missing got %0d pending want 0", q1.size());
    end else passed++;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_fall_rise();
    test_glitch();
    test_back_to_back();
    test_reset_pending();
    test_toggle();
    total++;
    if (q0.size() != 0) begin
      $display("FAIL dut0_missing got %0d pending want 0", q0.size());
    end else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/i2c_edge_detect.md
I2C_EDGE_DETECT -- requirements
Module: i2c_edge_detect

Interface
REQ-001 Parameter WIDTH, default 2, number of independent input channels (for example SCL and SDA); legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchroniser flops per channel; legal range 2..4.
REQ-003 Parameter FILTER_LEN, default 3, consecutive stable cycles needed to accept a new level; legal range 1..255; 1 means no filtering.
REQ-004 Parameter INIT_LEVEL, default 1'b1, reset level of all synchroniser and filtered-level flops (I2C idle-high).
REQ-005 clk  input  1  sole clock; all flops are rising-edge triggered.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 in  input  WIDTH  raw asynchronous channel inputs.
REQ-008 level  output  WIDTH  registered, filtered level per channel.
REQ-009 low_high_trans  output  WIDTH  per-channel one-cycle pulse on an accepted rising transition.
REQ-010 high_low_trans  output  WIDTH  per-channel one-cycle pulse on an accepted falling transition.
REQ-011 any_trans  output  1  registered OR of all bits of low_high_trans and high_low_trans, aligned with them.

Function
REQ-012 Each channel SHALL pass in[i] through a SYNC_STAGES-deep flop chain; the last stage is s[i].
REQ-013 Each channel SHALL hold a stability counter cnt[i], $clog2(FILTER_LEN+1) bits wide.
REQ-014 When s[i] == level[i], cnt[i] SHALL load 0 on the next edge.
REQ-015 When s[i] != level[i] and cnt[i] < FILTER_LEN-1, cnt[i] SHALL increment.
REQ-016 When s[i] != level[i] and cnt[i] == FILTER_LEN-1, the next edge SHALL load level[i] <= s[i] and cnt[i] <= 0.
REQ-017 On that same edge, the next edge SHALL set low_high_trans[i] to 1 if s[i] is 1, or high_low_trans[i] to 1 if s[i] is 0.
REQ-018 Per-channel state SHALL be IDLE (cnt==0, s==level) or PENDING (s!=level); PENDING returns to IDLE either on acceptance or on reversion with no pulse.
REQ-019 A glitch whose width at s[i] is shorter than FILTER_LEN cycles SHALL produce no pulse and no change to level.
REQ-020 Pulses SHALL last exactly one cycle; low_high_trans[i] and high_low_trans[i] SHALL never both be 1 in the same cycle.
REQ-021 Latency from a clean input step to its pulse SHALL be SYNC_STAGES+FILTER_LEN rising edges, with the pulse and the level change in the same cycle.
REQ-022 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL pulse in the same cycle.
REQ-023 The counter SHALL never exceed FILTER_LEN-1 and SHALL never wrap.
REQ-024 For FILTER_LEN=1, every synchronised change SHALL be accepted on the first edge after it appears at s[i].
REQ-025 An input toggling every cycle for FILTER_LEN>1 SHALL never produce a pulse.

Reset
REQ-026 While rst=1, all synchroniser flops and level SHALL be INIT_LEVEL, and all cnt, low_high_trans, high_low_trans and any_trans SHALL be 0, asynchronously.
REQ-027 After reset is released with in == INIT_LEVEL, no pulse SHALL occur.
REQ-028 After reset is released with in != INIT_LEVEL, exactly one pulse per differing channel SHALL occur after the REQ-021 latency.
REQ-029 Reset asserted during PENDING SHALL discard the pending transition; any pulse in flight SHALL clear immediately.

Verification (WIDTH=2, SYNC_STAGES=2, FILTER_LEN=3, INIT_LEVEL=1)
REQ-030 Hold in=2'b11 for 20 cycles after reset -> level=2'b11 and no pulses.
REQ-031 Drive in[0] 1->0 and hold -> high_low_trans=2'b01 for one cycle at edge 5 after the change, with level=2'b10 from that edge.
REQ-032 Drive a 2-cycle low glitch on in[1] -> no pulse, level unchanged, and cnt[1] back at 0.
REQ-033 Step both channels 1->0 in the same cycle, then back to 1 after 10 cycles -> high_low_trans=2'b11 once, then low_high_trans=2'b11 once, with any_trans high in both cycles.
REQ-034 Assert rst for 1 cycle, 2 cycles after a step on in[0] -> no pulse; level returns to 2'b11, then one high_low_trans[0] follows 5 edges after release.
REQ-035 Toggle in[0] every cycle for 50 cycles -> no pulses (FILTER_LEN=3); rerun with FILTER_LEN=1 -> one pulse per toggle, alternating between rising and falling.
